// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared shifter codes and shift sequencer state encodings
package shift_pkg;

    localparam logic [15:0] SH_DIR_LEFT  = 16'h0001;
    localparam logic [15:0] SH_DIR_RIGHT = 16'hFFFF;
    localparam logic [15:0] SH_DIR_NONE  = 16'h0000;

    localparam logic SH_LOGICAL = 1'b1;
    localparam logic SH_ARITH   = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-bit shift controller driving an external 1-bit shifter
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [AMT_W-1:0] amount,
    input  logic             shift_type,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sh_src,
    output logic [WIDTH-1:0] sh_dir,
    output logic             sh_type,
    input  logic [WIDTH-1:0] sh_out
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [AMT_W-1:0] cnt;
    logic             leftReg;
    logic             typeReg;
    logic [AMT_W-1:0] amountMag;
    logic             amountNeg;

    // Magnitude of the signed amount; -16 maps to 16 because cnt is read as unsigned.
    assign amountNeg = amount[AMT_W-1];
    assign amountMag = amountNeg ? ((~amount) + AMT_W'(1)) : amount;

    // The shifter always works on the accumulator with the captured shift type.
    assign sh_src  = acc;
    assign sh_type = typeReg;

    // Sequencer FSM: capture on start, one shifter step per SHIFT cycle, pulse done once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            leftReg <= 1'b0;
            typeReg <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            sh_dir  <= WIDTH'(SH_DIR_NONE);
        end else begin
            case (state)
                ST_IDLE: begin
                    done   <= 1'b0;
                    sh_dir <= WIDTH'(SH_DIR_NONE);
                    if (start) begin
                        acc     <= src;
                        typeReg <= shift_type;
                        leftReg <= ~amountNeg;
                        cnt     <= amountMag;
                        busy    <= 1'b1;
                        if (amount != '0) begin
                            state  <= ST_SHIFT;
                            sh_dir <= amountNeg ? WIDTH'(SH_DIR_RIGHT) : WIDTH'(SH_DIR_LEFT);
                        end else begin
                            // Zero amount skips SHIFT; result is the operand itself.
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            result <= src;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc <= sh_out;
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        // Result register mirrors the accumulator value held during DONE.
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        result <= sh_out;
                        sh_dir <= WIDTH'(SH_DIR_NONE);
                    end else begin
                        sh_dir <= leftReg ? WIDTH'(SH_DIR_LEFT) : WIDTH'(SH_DIR_RIGHT);
                    end
                end
                ST_DONE: begin
                    // Start is not sampled here; the next request is taken in IDLE.
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    sh_dir <= WIDTH'(SH_DIR_NONE);
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    sh_dir <= WIDTH'(SH_DIR_NONE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] src;
    logic [4:0]  amount;
    logic        shift_type;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] sh_src;
    logic [15:0] sh_dir;
    logic        sh_type;
    logic [15:0] sh_out;

    int checkCount = 0;
    int errorCount = 0;

    shift_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src        (src),
        .amount     (amount),
        .shift_type (shift_type),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sh_src     (sh_src),
        .sh_dir     (sh_dir),
        .sh_type    (sh_type),
        .sh_out     (sh_out)
    );

    // External single-bit shifter
    always_comb begin
        sh_out = sh_src;
        if (sh_dir == 16'h0001)
            sh_out = {sh_src[14:0], 1'b0};
        else if (sh_dir == 16'hFFFF)
            sh_out = sh_type ? {1'b0, sh_src[15:1]} : {sh_src[15], sh_src[15:1]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; checks every cycle up to and just after the done pulse.
    task automatic runOp(input string tag, input logic [15:0] s, input int amt,
                         input logic t, input logic [15:0] expRes);
        int          mag;
        logic [15:0] expDir;
        logic [31:0] amtBits;
        mag     = (amt < 0) ? -amt : amt;
        expDir  = (amt > 0) ? 16'h0001 : 16'hFFFF;
        amtBits = amt;
        @(negedge clk);
        src = s; amount = amtBits[4:0]; shift_type = t; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= mag; k++) begin
            @(negedge clk);
            checkVal({tag, ".dir"}, sh_dir, expDir);
            checkVal({tag, ".busy"}, busy, 1);
            checkVal({tag, ".early_done"}, done, 0);
        end
        @(negedge clk);
        checkVal({tag, ".done"}, done, 1);
        checkVal({tag, ".result"}, result, expRes);
        checkVal({tag, ".done_busy"}, busy, 1);
        checkVal({tag, ".done_dir"}, sh_dir, 0);
        @(negedge clk);
        checkVal({tag, ".pulse"}, done, 0);
        checkVal({tag, ".idle_busy"}, busy, 0);
        checkVal({tag, ".hold"}, result, expRes);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; src = '0; amount = '0; shift_type = 1'b0;
        #12;
        checkVal("rst.busy", busy, 0);
        checkVal("rst.done", done, 0);
        checkVal("rst.result", result, 0);
        checkVal("rst.sh_dir", sh_dir, 0);
        checkVal("rst.sh_src", sh_src, 0);
        @(negedge clk);
        reset_n = 1'b1;

        runOp("t1_left3", 16'h0001, 3, 1'b1, 16'h0008);
        runOp("t2_arith", 16'h8000, -4, 1'b0, 16'hF800);
        runOp("t2_logic", 16'h8000, -4, 1'b1, 16'h0800);
        runOp("t3_zero", 16'h1234, 0, 1'b1, 16'h1234);
        runOp("t4_logic16", 16'hFFFF, -16, 1'b1, 16'h0000);
        runOp("t4_arith16", 16'hFFFF, -16, 1'b0, 16'hFFFF);
        runOp("left15", 16'h0003, 15, 1'b0, 16'h8000);

        // Start held high throughout: later inputs must not disturb the running op.
        @(negedge clk);
        src = 16'hAAAA; amount = 5'd5; shift_type = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        src = 16'h0F0F; amount = 5'b11101; shift_type = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkVal("t5.dir", sh_dir, 16'h0001);
            checkVal("t5.type", sh_type, 1);
        end
        @(negedge clk);
        checkVal("t5.done", done, 1);
        checkVal("t5.result", result, 16'h5540);
        @(negedge clk);
        checkVal("t5.idle_busy", busy, 0);
        checkVal("t5.idle_done", done, 0);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkVal("t5b.dir", sh_dir, 16'hFFFF);
        end
        @(negedge clk);
        checkVal("t5b.done", done, 1);
        checkVal("t5b.result", result, 16'h01E1);

        // Reset asserted in the second SHIFT cycle aborts the op.
        @(negedge clk);
        src = 16'h00FF; amount = 5'd4; shift_type = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkVal("t6.busy1", busy, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkVal("t6.busy", busy, 0);
        checkVal("t6.done", done, 0);
        checkVal("t6.result", result, 0);
        checkVal("t6.sh_dir", sh_dir, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkVal("t6.no_done", done, 0);
        end

        runOp("recover", 16'h0F00, -2, 1'b0, 16'h03C0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
